instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 132 +++++++++++++
 tb/tb_instruction_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module  : instruction_fetch
// Brief   : PC sequencer with a two-entry {instruction, pc} FIFO between the
//           instruction memory and the control unit. Optional misaligned-
//           redirect trap enabled by macro IFETCH_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int                   WORDSIZE         = 64,
  parameter int                   INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0]  RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic                        imem_ack,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        redirect_en,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [WORDSIZE-1:0]         instr_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic                        fetch_misaligned
`endif
);

  localparam logic [WORDSIZE-1:0] c_pc_step  = WORDSIZE'(4);
  localparam logic [WORDSIZE-1:0] c_alignmsk = ~WORDSIZE'(3);

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT_SPACE = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT_SPACE = 2'd1} state_t;
`endif

  state_t                      r_state;
  logic [WORDSIZE-1:0]         r_fetch_pc;
  logic [INSTRUCTION_SIZE-1:0] r_instr_mem [2];
  logic [WORDSIZE-1:0]         r_pc_mem    [2];
  logic                        r_head;
  logic                        r_tail;
  logic [1:0]                  r_count;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic [WORDSIZE-1:0]         w_redirect_target;

  assign w_full      = (r_count == 2'd2);
  assign instr_valid = (r_count != 2'd0);
  assign instruction = r_instr_mem[r_head];
  assign instr_pc    = r_pc_mem[r_head];
  assign imem_addr   = r_fetch_pc;
  // State resets to FETCH, so the request is masked while reset is held.
  assign imem_req    = (r_state == FETCH) && !rst;

  assign w_pop  = instr_valid && instr_ready;
  assign w_push = (r_state == FETCH) && imem_ack && (!w_full || w_pop);

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned      = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_target = redirect_pc;
`else
  assign w_redirect_target = redirect_pc & c_alignmsk;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= FETCH;
      r_fetch_pc     <= RESET_PC;
      r_head         <= 1'b0;
      r_tail         <= 1'b0;
      r_count        <= 2'd0;
      r_instr_mem[0] <= '0;
      r_instr_mem[1] <= '0;
      r_pc_mem[0]    <= '0;
      r_pc_mem[1]    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_misaligned <= 1'b0;
`endif
    end else if (redirect_en) begin
      // Redirect flushes everything, including an ack landing this cycle.
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_fetch_pc <= w_redirect_target;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_misaligned <= w_misaligned;
      r_state          <= w_misaligned ? HALT : FETCH;
`else
      r_state    <= FETCH;
`endif
    end else begin
      if (w_push) begin
        r_instr_mem[r_tail] <= imem_rdata;
        r_pc_mem[r_tail]    <= r_fetch_pc;
        r_tail              <= ~r_tail;
        r_fetch_pc          <= r_fetch_pc + c_pc_step;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

      case (r_state)
        FETCH: begin
          if (w_push && !w_pop && (r_count == 2'd1)) begin
            r_state <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (w_pop) begin
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module  : tb_instruction_fetch
// Brief   : Directed self-checking bench for instruction_fetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word is its own low address bits xor a fixed tag.
  always_comb imem_rdata = imem_addr[31:0] ^ 32'hDEAD_0000;

  instruction_fetch #(
    .WORDSIZE         (64),
    .INSTRUCTION_SIZE (32),
    .RESET_PC         (64'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    check("rst_req",   64'(imem_req),    64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_ipc",   instr_pc,         64'd0);

    // Streaming: ack and ready held high
    rst = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
    #1;
    check("post_rst_req",  64'(imem_req),    64'd1);
    check("post_rst_addr", imem_addr,        64'd0);
    check("post_rst_vld",  64'(instr_valid), 64'd0);
    tick();
    check("stream_addr1",  imem_addr,        64'd4);
    check("stream_vld1",   64'(instr_valid), 64'd1);
    check("stream_pc1",    instr_pc,         64'd0);
    check("stream_ins1",   64'(instruction), 64'hDEAD_0000);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check("stream_addr", imem_addr, 64'(4 * k));
      check("stream_pc",   instr_pc,  64'(4 * (k - 1)));
    end

    // Stall: address stable while waiting for ack
    imem_ack = 1'b0; instr_ready = 1'b0;
    tick();
    check("stall_addr", imem_addr,      64'd20);
    check("stall_req",  64'(imem_req),  64'd1);

    // Reset mid-request, then a late ack during reset
    #2 rst = 1'b1;
    #1;
    check("midrst_req", 64'(imem_req),    64'd0);
    check("midrst_vld", 64'(instr_valid), 64'd0);
    check("midrst_ipc", instr_pc,         64'd0);
    imem_ack = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rel_addr", imem_addr,        64'd0);
    check("rel_req",  64'(imem_req),    64'd1);
    check("rel_vld",  64'(instr_valid), 64'd0);

    // Backpressure: two pushes then request stops
    tick();
    check("bp_req1", 64'(imem_req), 64'd1);
    check("bp_pc1",  instr_pc,      64'd0);
    tick();
    check("bp_req2", 64'(imem_req), 64'd0);
    tick();
    check("bp_req3", 64'(imem_req), 64'd0);
    check("bp_pc3",  instr_pc,      64'd0);
    instr_ready = 1'b1;
    tick();
    check("bp_pop_req",  64'(imem_req), 64'd1);
    check("bp_pop_addr", imem_addr,     64'd8);
    check("bp_pop_pc",   instr_pc,      64'd4);
    instr_ready = 1'b0;
    tick();
    check("bp_refill_req", 64'(imem_req), 64'd0);

    // Redirect with full FIFO and ack asserted
    redirect_en = 1'b1; redirect_pc = 64'h100;
    tick();
    check("redir_vld",  64'(instr_valid), 64'd0);
    check("redir_addr", imem_addr,        64'h100);
    check("redir_req",  64'(imem_req),    64'd1);
    redirect_en = 1'b0; instr_ready = 1'b1;
    tick();
    check("redir_pc",   instr_pc,         64'h100);
    check("redir_ins",  64'(instruction), 64'hDEAD_0100);
    check("redir_nxt",  imem_addr,        64'h104);

    // Misaligned redirect, concurrent with a handshake
    redirect_en = 1'b1; redirect_pc = 64'h102;
    tick();
    check("mis_vld", 64'(instr_valid), 64'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis_flag", 64'(fetch_misaligned), 64'd1);
    check("mis_req",  64'(imem_req),         64'd0);
    redirect_en = 1'b0;
    tick();
    check("halt_req", 64'(imem_req),    64'd0);
    check("halt_vld", 64'(instr_valid), 64'd0);
`else
    check("mis_addr", imem_addr,     64'h100);
    check("mis_req",  64'(imem_req), 64'd1);
    redirect_en = 1'b0;
    tick();
    check("mis_pc",   instr_pc,      64'h100);
`endif
    redirect_en = 1'b1; redirect_pc = 64'h200;
    tick();
    check("align_addr", imem_addr,     64'h200);
    check("align_req",  64'(imem_req), 64'd1);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("align_flag", 64'(fetch_misaligned), 64'd0);
`endif

    // PC wrap at the top of the address space
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    check("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    redirect_en = 1'b0;
    tick();
    check("wrap_addr", imem_addr,        64'd0);
    check("wrap_pc",   instr_pc,         64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_ins",  64'(instruction), 64'h2152_FFFC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
